// File: rtl/wb_store_buffer_if.sv
// Writeback-to-dcache store buffer bus: store push, dcache drain and load probe.
// Signal names match the legacy port list so existing connections map one-to-one.
interface wb_store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          WB_Final_Dcache_Write;
  logic [31:0]   WB_Final_Dcache_Address;
  logic [63:0]   WB_Final_Dcache_Data;
  logic [1:0]    WB_Final_datasize;
  logic          In_write_ready;

  logic          SB_dc_req;
  logic [31:0]   SB_dc_addr;
  logic [63:0]   SB_dc_data;
  logic [1:0]    SB_dc_size;
  logic          DC_sb_ack;

  logic          LD_V;
  logic [31:0]   LD_ADDR;
  logic          SB_ld_conflict;

  logic          SB_empty;
  logic [CW-1:0] SB_count;

  modport master (
    output WB_Final_Dcache_Write, WB_Final_Dcache_Address, WB_Final_Dcache_Data,
    output WB_Final_datasize, DC_sb_ack, LD_V, LD_ADDR,
    input  In_write_ready, SB_dc_req, SB_dc_addr, SB_dc_data, SB_dc_size,
    input  SB_ld_conflict, SB_empty, SB_count
  );

  modport slave (
    input  WB_Final_Dcache_Write, WB_Final_Dcache_Address, WB_Final_Dcache_Data,
    input  WB_Final_datasize, DC_sb_ack, LD_V, LD_ADDR,
    output In_write_ready, SB_dc_req, SB_dc_addr, SB_dc_data, SB_dc_size,
    output SB_ld_conflict, SB_empty, SB_count
  );
endinterface

// File: rtl/wb_store_buffer.sv
// Circular FIFO of retired stores between writeback and the dcache, with a
// qword-granular load-overlap probe against pending entries.
module wb_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic             CLK,
  input logic             CLR,
  wb_store_buffer_if.slave sb
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] QW_MASK = 32'hFFFF_FFF8;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic [31:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];

  logic write_ready;
  logic dc_req;
  logic push;
  logic pop;
  logic ld_hit;

  // Ready and request come only from registered occupancy, never from inputs.
  assign write_ready = (count != FULL);
  assign dc_req      = (count != '0);
  assign push        = sb.WB_Final_Dcache_Write & write_ready;
  assign pop         = dc_req & sb.DC_sb_ack;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= sb.WB_Final_Dcache_Address;
        data_q[tail] <= sb.WB_Final_Dcache_Data;
        size_q[tail] <= sb.WB_Final_datasize;
        valid[tail]  <= 1'b1;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (((addr_q[i] ^ sb.LD_ADDR) & QW_MASK) == '0)) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign sb.In_write_ready = write_ready;
  assign sb.SB_dc_req      = dc_req;
  assign sb.SB_dc_addr     = dc_req ? addr_q[head] : '0;
  assign sb.SB_dc_data     = dc_req ? data_q[head] : '0;
  assign sb.SB_dc_size     = dc_req ? size_q[head] : '0;
  assign sb.SB_ld_conflict = sb.LD_V & ld_hit;
  assign sb.SB_empty       = ~dc_req;
  assign sb.SB_count       = count;
endmodule

// File: tb/tb_wb_store_buffer.sv
// Directed and randomized checks of wb_store_buffer against a queue-based
// model of the pending stores.
module tb_wb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } store_t;

  logic CLK = 1'b0;
  logic CLR = 1'b1;

  wb_store_buffer_if #(.DEPTH(DEPTH)) sb ();

  wb_store_buffer #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .sb  (sb.slave)
  );

  always #5 CLK = ~CLK;

  store_t      q[$];
  logic [63:0] seen[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic wr, input logic [31:0] a, input logic [63:0] d,
                        input logic [1:0] s, input logic ack);
    sb.WB_Final_Dcache_Write   = wr;
    sb.WB_Final_Dcache_Address = a;
    sb.WB_Final_Dcache_Data    = d;
    sb.WB_Final_datasize       = s;
    sb.DC_sb_ack               = ack;
  endtask

  // Compare every output against what the pending-store queue implies.
  task automatic check_all(input string tag);
    store_t h;
    logic   conf;
    #1;
    h    = (q.size() != 0) ? q[0] : '0;
    conf = 1'b0;
    foreach (q[i]) if (q[i].addr[31:3] == sb.LD_ADDR[31:3]) conf = 1'b1;
    conf = conf & sb.LD_V;
    chk({tag, ".ready"}, 64'(sb.In_write_ready), 64'(q.size() != DEPTH));
    chk({tag, ".req"},   64'(sb.SB_dc_req),      64'(q.size() != 0));
    chk({tag, ".addr"},  64'(sb.SB_dc_addr),     64'(h.addr));
    chk({tag, ".data"},  sb.SB_dc_data,          h.data);
    chk({tag, ".size"},  64'(sb.SB_dc_size),     64'(h.size));
    chk({tag, ".empty"}, 64'(sb.SB_empty),       64'(q.size() == 0));
    chk({tag, ".count"}, 64'(sb.SB_count),       64'(q.size()));
    chk({tag, ".conf"},  64'(sb.SB_ld_conflict), 64'(conf));
  endtask

  // One clock: decide push/pop from the model state and inputs before the edge.
  task automatic step(input string tag);
    bit     push, pop;
    store_t n;
    push = !CLR && sb.WB_Final_Dcache_Write && (q.size() < DEPTH);
    pop  = !CLR && sb.DC_sb_ack && (q.size() > 0);
    n    = '{sb.WB_Final_Dcache_Address, sb.WB_Final_Dcache_Data, sb.WB_Final_datasize};
    if (pop) seen.push_back(sb.SB_dc_data);
    @(posedge CLK);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(n);
    if (CLR) q.delete();
    check_all(tag);
  endtask

  task automatic drain();
    set_in(1'b0, '0, '0, 2'b00, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step("drain");
    sb.DC_sb_ack = 1'b0;
  endtask

  initial begin
    set_in(1'b0, '0, '0, 2'b00, 1'b0);
    sb.LD_V    = 1'b0;
    sb.LD_ADDR = '0;
    check_all("reset");
    step("reset_clk");
    CLR = 1'b0;
    step("idle");

    // Single store, one-cycle latency, single ack.
    set_in(1'b1, 32'h0000_1008, 64'hAB, 2'b00, 1'b0);
    chk("single.no_bypass", 64'(sb.SB_dc_req), 64'd0);
    step("single.push");
    chk("single.req", 64'(sb.SB_dc_req), 64'd1);
    chk("single.addr", 64'(sb.SB_dc_addr), 64'h1008);
    chk("single.count", 64'(sb.SB_count), 64'd1);
    set_in(1'b0, '0, '0, 2'b00, 1'b1);
    step("single.ack");
    chk("single.empty", 64'(sb.SB_empty), 64'd1);
    sb.DC_sb_ack = 1'b0;
    step("single.idle");

    // Fill, hold fifth store, one ack releases a slot.
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 32'h100 + 32'(k * 8), 64'(k), 2'b01, 1'b0);
      step("fill.push");
    end
    chk("fill.ready", 64'(sb.In_write_ready), 64'd0);
    chk("fill.count", 64'(sb.SB_count), 64'd4);
    set_in(1'b1, 32'h128, 64'd5, 2'b10, 1'b0);
    step("fill.held");
    chk("fill.held_count", 64'(sb.SB_count), 64'd4);
    sb.DC_sb_ack = 1'b1;
    step("fill.ack");
    chk("fill.ready_after_ack", 64'(sb.In_write_ready), 64'd1);
    sb.DC_sb_ack = 1'b0;
    step("fill.fifth");
    chk("fill.fifth_count", 64'(sb.SB_count), 64'd4);
    drain();

    // Wrap and order with continuous ack.
    seen.delete();
    for (int k = 1; k <= 6; k++) begin
      set_in(1'b1, 32'h400 + 32'(k * 8), 64'(k), 2'b11, 1'b1);
      step("wrap.push");
    end
    set_in(1'b0, '0, '0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step("wrap.tail");
    chk("wrap.seen_n", 64'(seen.size()), 64'd6);
    for (int k = 0; k < 6 && k < seen.size(); k++) chk("wrap.order", seen[k], 64'(k + 1));
    chk("wrap.final_count", 64'(sb.SB_count), 64'd0);
    sb.DC_sb_ack = 1'b0;

    // Simultaneous push and pop at count 2.
    set_in(1'b1, 32'h800, 64'hA1, 2'b00, 1'b0);
    step("pp.push1");
    set_in(1'b1, 32'h808, 64'hA2, 2'b00, 1'b0);
    step("pp.push2");
    set_in(1'b1, 32'h810, 64'hA3, 2'b00, 1'b1);
    step("pp.both");
    chk("pp.count", 64'(sb.SB_count), 64'd2);
    chk("pp.head", sb.SB_dc_data, 64'hA2);
    drain();

    // Qword-granular load conflict.
    set_in(1'b1, 32'h2004, 64'h55, 2'b01, 1'b0);
    step("conf.push");
    sb.WB_Final_Dcache_Write = 1'b0;
    sb.LD_V = 1'b1; sb.LD_ADDR = 32'h2000;
    check_all("conf.same_qw");
    chk("conf.hit", 64'(sb.SB_ld_conflict), 64'd1);
    sb.LD_ADDR = 32'h2008;
    check_all("conf.next_qw");
    chk("conf.miss", 64'(sb.SB_ld_conflict), 64'd0);
    sb.LD_V = 1'b0; sb.LD_ADDR = 32'h2000;
    check_all("conf.ldv0");
    chk("conf.off", 64'(sb.SB_ld_conflict), 64'd0);
    drain();

    // Asynchronous reset with three pending stores and an ack in flight.
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 32'h3000 + 32'(k * 8), 64'(k + 16), 2'b10, 1'b0);
      step("rst.push");
    end
    set_in(1'b0, '0, '0, 2'b00, 1'b1);
    sb.LD_V = 1'b1; sb.LD_ADDR = 32'h3008;
    #2;
    CLR = 1'b1;
    q.delete();
    check_all("rst.async");
    chk("rst.req", 64'(sb.SB_dc_req), 64'd0);
    chk("rst.conf", 64'(sb.SB_ld_conflict), 64'd0);
    step("rst.held");
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) step("rst.after");
    sb.LD_V = 1'b0;
    sb.DC_sb_ack = 1'b0;

    // Randomized traffic over a small address pool so probes hit.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) < 6),
             32'h5000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7)),
             {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1));
      sb.LD_V    = ($urandom_range(0, 1) == 1);
      sb.LD_ADDR = 32'h5000 + 32'($urandom_range(0, 8) * 8) + 32'($urandom_range(0, 7));
      check_all("rand.pre");
      step("rand");
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_store_buffer.md
WB_STORE_BUFFER -- requirements
Module: wb_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of store entries, a power of two, minimum 2.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port CLR, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port WB_Final_Dcache_Write, input, 1: the writeback stage presents a valid store this cycle.
REQ-005 SHALL have port WB_Final_Dcache_Address, input, 32: store byte address.
REQ-006 SHALL have port WB_Final_Dcache_Data, input, 64: store data, right-aligned.
REQ-007 SHALL have port WB_Final_datasize, input, 2: store size; 00=byte, 01=word, 10=dword, 11=qword (MM).
REQ-008 SHALL have port In_write_ready, output, 1: buffer can accept a store this cycle.
REQ-009 SHALL have port SB_dc_req, output, 1: head entry is valid and is offered to the dcache.
REQ-010 SHALL have port SB_dc_addr, output, 32: address of the head entry.
REQ-011 SHALL have port SB_dc_data, output, 64: data of the head entry.
REQ-012 SHALL have port SB_dc_size, output, 2: size of the head entry.
REQ-013 SHALL have port DC_sb_ack, input, 1: the dcache has accepted the head entry this cycle.
REQ-014 SHALL have port LD_V, input, 1: a memory-stage load probe is valid.
REQ-015 SHALL have port LD_ADDR, input, 32: load probe address.
REQ-016 SHALL have port SB_ld_conflict, output, 1: the load overlaps a pending store.
REQ-017 SHALL have port SB_empty, output, 1: no pending entries; used by halt and serialising logic.
REQ-018 SHALL have port SB_count, output, log2(DEPTH)+1: number of occupied entries.

Function
REQ-019 SHALL implement a circular FIFO:
- head pointer and tail pointer, each log2(DEPTH) bits;
- occupancy counter, 0..DEPTH;
- per-entry valid, addr[31:0], data[63:0] and size[1:0].
REQ-020 In_write_ready SHALL equal (count != DEPTH). It SHALL be decoded from registered state only, with no combinational path from any input.
REQ-021 Push: when WB_Final_Dcache_Write=1 and In_write_ready=1, the buffer SHALL:
- write addr, data and size into the entry at the tail;
- set that entry's valid bit;
- advance tail modulo DEPTH at the clock edge.
REQ-022 WB_Final_Dcache_Write=1 while In_write_ready=0 SHALL cause no state change. Writeback holds the store and stalls.
REQ-023 SB_dc_req SHALL equal (count != 0). SB_dc_addr, SB_dc_data and SB_dc_size SHALL show the head entry. They SHALL be zero when the buffer is empty.
REQ-024 Pop: when SB_dc_req=1 and DC_sb_ack=1, the buffer SHALL clear the head entry's valid bit and advance head modulo DEPTH. DC_sb_ack while SB_dc_req=0 SHALL be ignored.
REQ-025 The head outputs SHALL stay stable while SB_dc_req=1 and DC_sb_ack=0.
REQ-026 Latency: a store pushed into an empty buffer SHALL appear on SB_dc_req exactly one cycle later. There SHALL be no same-cycle bypass.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
- When the buffer is full, push is blocked by REQ-020, so only the pop takes effect.
- When the buffer is empty, pop is blocked by REQ-024, so only the push takes effect.
REQ-028 Count update:
- count+1 on push only;
- count-1 on pop only;
- unchanged otherwise.
- count SHALL never exceed DEPTH and SHALL never underflow.
REQ-029 Pointer wrap: when a pointer equal to DEPTH-1 is incremented, it SHALL become 0.
REQ-030 SB_ld_conflict SHALL be 1 when LD_V=1 and any valid entry has addr[31:3] equal to LD_ADDR[31:3].
- The compare is a qword-granular overlap check.
- Same-cycle incoming stores SHALL NOT be compared.
- The output is combinational from LD_V, LD_ADDR and registered entries.
REQ-031 SB_empty SHALL equal (count == 0). SB_count SHALL equal the registered count.
REQ-032 Store order to the dcache SHALL be strict FIFO program order.

Reset
REQ-033 When CLR is asserted, the buffer SHALL immediately, without waiting for a clock edge:
- set head, tail and count to 0;
- clear all valid bits;
- drive In_write_ready=1, SB_dc_req=0, SB_empty=1, SB_ld_conflict=0, SB_count=0.
REQ-034 Entry data and address registers SHALL reset to 0.
REQ-035 CLR asserted mid-operation SHALL discard all pending stores with no dcache request issued. Any DC_sb_ack arriving in that cycle SHALL be ignored.
REQ-036 After CLR deasserts, the first push SHALL occur no earlier than the next rising CLK edge.

Verification
REQ-037 Single store: push addr=0x0000_1008, data=0xAB, size=00 with DC_sb_ack held 0 ->
- next cycle SB_dc_req=1, SB_dc_addr=0x1008, SB_count=1;
- ack one cycle -> SB_empty=1 the following cycle.
REQ-038 Fill: push 5 stores back-to-back with no ack ->
- after 4 pushes, In_write_ready=0 and SB_count=4;
- the 5th store is not accepted and is held by the source;
- one ack -> In_write_ready=1 the next cycle, and the 5th store is then accepted.
REQ-039 Wrap and order: push 6 stores with data 1..6, acking continuously from the first SB_dc_req ->
- the dcache sees data 1,2,3,4,5,6 in order;
- pointers wrap past 3 to 0;
- final SB_count=0.
REQ-040 Simultaneous push and pop at count=2 -> count stays 2 and the head advances to the next entry.
REQ-041 Conflict: pending store at 0x2004, LD_V=1 ->
- LD_ADDR=0x2000 gives SB_ld_conflict=1;
- LD_ADDR=0x2008 gives SB_ld_conflict=0;
- LD_V=0 gives 0.
REQ-042 Reset mid-operation: with 3 entries pending, assert CLR between clock edges ->
- outputs go to their reset values immediately;
- no further SB_dc_req until a new push.
